// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: slot allocation, CDB wakeup of
// operand readiness, and oldest-ready selection via an age matrix.
module rs_issue_scheduler #(
  parameter int RSEntries        = 8,
  parameter int RSIdxBits        = 3,
  parameter int TagBits          = 6,
  parameter int RStationInstance = 0
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 stall_i,
  input  logic [TagBits-1:0]   srcATag_i,
  input  logic                 srcAReady_i,
  input  logic [TagBits-1:0]   srcBTag_i,
  input  logic                 srcBReady_i,
  input  logic                 cdbValid_i,
  input  logic [TagBits-1:0]   cdbTag_i,
  output logic [RSIdxBits-1:0] allocIdx_o,
  output logic                 full_o,
  output logic                 issueValid_o,
  output logic [RSIdxBits-1:0] issueIdx_o,
  output logic [RSIdxBits:0]   occupancy_o
);

  // Reject inconsistent parameterisations at elaboration.
  if (RSEntries < 2 || RSEntries > 32) begin : g_bad_entries
    $error("rs_issue_scheduler: RSEntries out of range");
  end
  if (RSIdxBits != $clog2(RSEntries)) begin : g_bad_idx
    $error("rs_issue_scheduler: RSIdxBits must equal clog2(RSEntries)");
  end
  if (RStationInstance < 0) begin : g_bad_inst
    $error("rs_issue_scheduler: RStationInstance must be non-negative");
  end

  logic [RSEntries-1:0] valid_q, valid_d;
  logic [RSEntries-1:0] a_rdy_q, a_rdy_d;
  logic [RSEntries-1:0] b_rdy_q, b_rdy_d;
  logic [TagBits-1:0]   a_tag_q [RSEntries];
  logic [TagBits-1:0]   a_tag_d [RSEntries];
  logic [TagBits-1:0]   b_tag_q [RSEntries];
  logic [TagBits-1:0]   b_tag_d [RSEntries];
  // older_q[i][j]: slot i was allocated before slot j
  logic [RSEntries-1:0] older_q [RSEntries];
  logic [RSEntries-1:0] older_d [RSEntries];
  logic                 issue_valid_q, issue_valid_d;
  logic [RSIdxBits-1:0] issue_idx_q, issue_idx_d;
  logic [RSIdxBits:0]   occupancy_q, occupancy_d;

  logic [RSIdxBits-1:0] alloc_idx;
  logic                 alloc_found;
  logic                 full;
  logic                 accept;
  logic [RSEntries-1:0] cand;
  logic [RSEntries-1:0] win_vec;
  logic [RSEntries-1:0] older_col;
  logic [RSIdxBits-1:0] win_idx;
  logic                 win_found;
  logic                 issue_fire;

  // Free-slot search: lowest-index invalid slot, full when none remain.
  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int unsigned i = 0; i < RSEntries; i++) begin
      if (!valid_q[i] && !alloc_found) begin
        alloc_idx   = RSIdxBits'(i);
        alloc_found = 1'b1;
      end
    end
    full   = &valid_q;
    accept = enable_i && !full;
  end

  // Oldest-ready select: a candidate wins when no other candidate is older.
  always_comb begin
    cand      = valid_q & a_rdy_q & b_rdy_q;
    win_vec   = '0;
    older_col = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < RSEntries; i++) begin
      for (int unsigned j = 0; j < RSEntries; j++) begin
        older_col[j] = older_q[j][i];
      end
      win_vec[i] = cand[i] && !(|(cand & older_col));
    end
    for (int unsigned i = 0; i < RSEntries; i++) begin
      if (win_vec[i] && !win_found) begin
        win_idx   = RSIdxBits'(i);
        win_found = 1'b1;
      end
    end
    issue_fire = !stall_i && win_found;
  end

  // Next-state: wakeup, issue free, dispatch write and age-matrix update.
  always_comb begin
    valid_d       = valid_q;
    a_rdy_d       = a_rdy_q;
    b_rdy_d       = b_rdy_q;
    a_tag_d       = a_tag_q;
    b_tag_d       = b_tag_q;
    older_d       = older_q;
    issue_valid_d = issue_fire;
    issue_idx_d   = issue_fire ? win_idx : issue_idx_q;
    occupancy_d   = occupancy_q + (RSIdxBits+1)'(accept) - (RSIdxBits+1)'(issue_fire);
    if (cdbValid_i) begin
      for (int unsigned i = 0; i < RSEntries; i++) begin
        if (valid_q[i] && a_tag_q[i] == cdbTag_i) a_rdy_d[i] = 1'b1;
        if (valid_q[i] && b_tag_q[i] == cdbTag_i) b_rdy_d[i] = 1'b1;
      end
    end
    if (issue_fire) valid_d[win_idx] = 1'b0;
    // The allocated slot is invalid now, so it never collides with the winner.
    if (accept) begin
      valid_d[alloc_idx] = 1'b1;
      a_tag_d[alloc_idx] = srcATag_i;
      b_tag_d[alloc_idx] = srcBTag_i;
      a_rdy_d[alloc_idx] = srcAReady_i | (cdbValid_i && cdbTag_i == srcATag_i);
      b_rdy_d[alloc_idx] = srcBReady_i | (cdbValid_i && cdbTag_i == srcBTag_i);
      older_d[alloc_idx] = '0;
      for (int unsigned j = 0; j < RSEntries; j++) begin
        older_d[j][alloc_idx] = valid_q[j] && !(issue_fire && win_idx == RSIdxBits'(j));
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q       <= '0;
      a_rdy_q       <= '0;
      b_rdy_q       <= '0;
      a_tag_q       <= '{default: '0};
      b_tag_q       <= '{default: '0};
      older_q       <= '{default: '0};
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      occupancy_q   <= '0;
    end else begin
      valid_q       <= valid_d;
      a_rdy_q       <= a_rdy_d;
      b_rdy_q       <= b_rdy_d;
      a_tag_q       <= a_tag_d;
      b_tag_q       <= b_tag_d;
      older_q       <= older_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      occupancy_q   <= occupancy_d;
    end
  end

  assign allocIdx_o   = alloc_idx;
  assign full_o       = full;
  assign issueValid_o = issue_valid_q;
  assign issueIdx_o   = issue_idx_q;
  assign occupancy_o  = occupancy_q;

endmodule
